// File: rtl/otter_pkg.sv
// Shared types and constants for the OTTER PC/fetch slice: next-PC select
// encoding, fetch FSM states and the reset instruction word.
package otter_pkg;

   typedef enum logic [2:0] {
      PC_PLUS4 = 3'd0,
      JALR     = 3'd1,
      BRANCH   = 3'd2,
      JAL      = 3'd3,
      MTVEC    = 3'd4,
      MEPC     = 3'd5
   } pc_src_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] PC_STEP   = 32'h0000_0004;

   // Clears the two low address bits so only word-aligned PCs are loaded.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection from pc_src and the branch decision.
// Unused encodings fall back to the sequential address.
module next_pc_mux
   import otter_pkg::*;
(
   input  logic [2:0]  pc_src,
   input  logic        take_branch,
   input  logic [31:0] pc_plus4,
   input  logic [31:0] jal_tgt,
   input  logic [31:0] jalr_tgt,
   input  logic [31:0] branch_tgt,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   output logic [31:0] next_pc
);

   // Target select; JALR target has bit 0 cleared.
   always_comb begin
      next_pc = pc_plus4;
      case (pc_src)
         PC_PLUS4: next_pc = pc_plus4;
         JALR:     next_pc = jalr_tgt & 32'hFFFF_FFFE;
         BRANCH: begin
            if (take_branch) begin
               next_pc = branch_tgt;
            end else begin
               next_pc = pc_plus4;
            end
         end
         JAL:      next_pc = jal_tgt;
         MTVEC:    next_pc = mtvec;
         MEPC:     next_pc = mepc;
         default:  next_pc = pc_plus4;
      endcase
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// OTTER program counter and instruction-fetch handshake controller.
// Optional feature macro: PC_MISALIGN_TRAP_EN (rejects misaligned commits, adds misalign).
module pc_fetch_ctrl
   import otter_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pc_write,
   input  logic [2:0]  pc_src,
   input  logic        take_branch,
   input  logic [31:0] jal_tgt,
   input  logic [31:0] jalr_tgt,
   input  logic [31:0] branch_tgt,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   output logic        fetch_req,
   output logic [31:0] fetch_addr,
   input  logic        fetch_ack,
   input  logic [31:0] fetch_data,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4
`ifdef PC_MISALIGN_TRAP_EN
   ,
   output logic        misalign
`endif
);

   fetch_state_e state_r;
   fetch_state_e state_s;
   logic [31:0]  pc_r;
   logic [31:0]  instr_r;
   logic         instr_valid_r;
   logic         fetch_req_r;
   logic [31:0]  next_pc_s;
   logic         load_pc_s;
   logic         latch_s;
`ifdef PC_MISALIGN_TRAP_EN
   logic         misalign_r;
   logic         misalign_s;
`endif

   assign pc          = pc_r;
   assign fetch_addr  = pc_r;
   assign pc_plus4    = pc_r + PC_STEP;
   assign instr       = instr_r;
   assign instr_valid = instr_valid_r;
   assign fetch_req   = fetch_req_r;
`ifdef PC_MISALIGN_TRAP_EN
   assign misalign    = misalign_r;
`endif

   next_pc_mux u_next_pc_mux (
      .pc_src      (pc_src),
      .take_branch (take_branch),
      .pc_plus4    (pc_plus4),
      .jal_tgt     (jal_tgt),
      .jalr_tgt    (jalr_tgt),
      .branch_tgt  (branch_tgt),
      .mtvec       (mtvec),
      .mepc        (mepc),
      .next_pc     (next_pc_s)
   );

   // Next-state and register-enable decode for the fetch FSM.
   always_comb begin
      state_s   = state_r;
      load_pc_s = 1'b0;
      latch_s   = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign_s = 1'b0;
`endif
      case (state_r)
         IDLE: state_s = FETCH;
         FETCH: begin
            if (fetch_ack) begin
               latch_s = 1'b1;
               state_s = DONE;
            end else begin
               state_s = FETCH;
            end
         end
         DONE: begin
            if (pc_write) begin
`ifdef PC_MISALIGN_TRAP_EN
               // A misaligned target is refused; the control FSM re-commits via MTVEC.
               if (next_pc_s[1:0] != 2'b00) begin
                  misalign_s = 1'b1;
                  state_s    = DONE;
               end else begin
                  load_pc_s = 1'b1;
                  state_s   = FETCH;
               end
`else
               load_pc_s = 1'b1;
               state_s   = FETCH;
`endif
            end else begin
               state_s = DONE;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State, PC, instruction and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         pc_r          <= RESET_VEC;
         instr_r       <= NOP_INSTR;
         instr_valid_r <= 1'b0;
         fetch_req_r   <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
         misalign_r    <= 1'b0;
`endif
      end else begin
         state_r       <= state_s;
         fetch_req_r   <= (state_s == FETCH);
         instr_valid_r <= (state_s == DONE);
`ifdef PC_MISALIGN_TRAP_EN
         misalign_r    <= misalign_s;
`endif
         if (load_pc_s) begin
            pc_r <= word_align(next_pc_s);
         end else begin
            pc_r <= pc_r;
         end
         if (latch_s) begin
            instr_r <= fetch_data;
         end else begin
            instr_r <= instr_r;
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed scoreboard bench for pc_fetch_ctrl; expected fetch addresses and
// instructions are queued at stimulus time and popped when the DUT responds.
module tb_pc_fetch_ctrl;
   import otter_pkg::*;

   localparam logic [31:0] RV = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pc_write = 1'b0;
   logic [2:0]  pc_src = 3'd0;
   logic        take_branch = 1'b0;
   logic [31:0] jal_tgt = 32'h0;
   logic [31:0] jalr_tgt = 32'h0;
   logic [31:0] branch_tgt = 32'h0;
   logic [31:0] mtvec = 32'h0;
   logic [31:0] mepc = 32'h0;
   logic        fetch_ack = 1'b0;
   logic [31:0] fetch_data = 32'h0;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
`ifdef PC_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   int n_checks = 0;
   int n_pass = 0;
   logic [31:0] addr_q[$];
   logic [31:0] instr_q[$];
   logic [31:0] exp_pc = 32'h0;
   logic [31:0] last_instr = 32'h0000_0013;

   pc_fetch_ctrl #(.RESET_VEC(RV)) dut (
      .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .pc_src(pc_src),
      .take_branch(take_branch), .jal_tgt(jal_tgt), .jalr_tgt(jalr_tgt),
      .branch_tgt(branch_tgt), .mtvec(mtvec), .mepc(mepc),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
      .fetch_data(fetch_data), .instr(instr), .instr_valid(instr_valid),
      .pc(pc), .pc_plus4(pc_plus4)
`ifdef PC_MISALIGN_TRAP_EN
      , .misalign(misalign)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Bounded wait for a fetch request, then compare against the queued address.
   task automatic await_req(input string tag);
      int budget = 0;
      while (fetch_req !== 1'b1 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      check({tag, "_req"}, {31'd0, fetch_req}, 32'd1);
      check({tag, "_qdepth"}, addr_q.size(), 32'd1);
      if (addr_q.size() > 0) exp_pc = addr_q.pop_front();
      check({tag, "_addr"}, fetch_addr, exp_pc);
      check({tag, "_pc"}, pc, exp_pc);
      check({tag, "_p4"}, pc_plus4, exp_pc + 32'd4);
   endtask

   task automatic commit(input string tag, input logic [2:0] src, input logic [31:0] exp);
      pc_src = src;
      pc_write = 1'b1;
      addr_q.push_back(exp);
      @(negedge clk);
      pc_write = 1'b0;
      check({tag, "_ivfall"}, {31'd0, instr_valid}, 32'd0);
      await_req(tag);
   endtask

   task automatic fetch(input string tag, input logic [31:0] data, input int waits);
      for (int i = 0; i < waits; i++) begin
         check({tag, "_waitaddr"}, fetch_addr, exp_pc);
         check({tag, "_waitiv"}, {31'd0, instr_valid}, 32'd0);
         @(negedge clk);
      end
      check({tag, "_ackaddr"}, fetch_addr, exp_pc);
      fetch_ack = 1'b1;
      fetch_data = data;
      instr_q.push_back(data);
      @(negedge clk);
      fetch_ack = 1'b0;
      fetch_data = 32'hBAD0_BAD0;
      check({tag, "_iv"}, {31'd0, instr_valid}, 32'd1);
      check({tag, "_reqfall"}, {31'd0, fetch_req}, 32'd0);
      if (instr_q.size() > 0) last_instr = instr_q.pop_front();
      check({tag, "_instr"}, instr, last_instr);
   endtask

   initial begin
      #12;
      check("rst_pc", pc, RV);
      check("rst_instr", instr, NOP_INSTR);
      check("rst_iv", {31'd0, instr_valid}, 32'd0);
      check("rst_req", {31'd0, fetch_req}, 32'd0);
`ifdef PC_MISALIGN_TRAP_EN
      check("rst_mis", {31'd0, misalign}, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      addr_q.push_back(RV);
      @(negedge clk);
      await_req("first");
      fetch("first", 32'h0050_0093, 0);

      commit("seq", PC_PLUS4, 32'h104);
      fetch("seq", 32'h1111_0001, 3);

      branch_tgt = 32'h200;
      take_branch = 1'b0;
      commit("bnt", BRANCH, 32'h108);
      fetch("bnt", 32'h1111_0002, 0);
      take_branch = 1'b1;
      commit("bt", BRANCH, 32'h200);
      fetch("bt", 32'h1111_0003, 1);
      take_branch = 1'b0;

      jalr_tgt = 32'h301;
      commit("jalr", JALR, 32'h300);
      fetch("jalr", 32'h1111_0004, 0);
      jal_tgt = 32'hFFFF_FFFC;
      commit("jal", JAL, 32'hFFFF_FFFC);
      fetch("jal", 32'h1111_0005, 0);
      commit("wrap", PC_PLUS4, 32'h0);
      fetch("wrap", 32'h1111_0006, 0);

      mtvec = 32'h400;
      commit("mtvec", MTVEC, 32'h400);
      fetch("mtvec", 32'h1111_0007, 0);
      mepc = 32'h508;
      commit("mepc", MEPC, 32'h508);
      fetch("mepc", 32'h1111_0008, 0);
      commit("enc6", 3'd6, 32'h50C);
      fetch("enc6", 32'h1111_0009, 0);
      commit("enc7", 3'd7, 32'h510);
      fetch("enc7", 32'h1111_000A, 0);
      take_branch = 1'b1;
      commit("p4tb", PC_PLUS4, 32'h514);
      take_branch = 1'b0;

      // Commit while fetching must be ignored.
      jal_tgt = 32'h700;
      pc_src = JAL;
      pc_write = 1'b1;
      @(negedge clk);
      pc_write = 1'b0;
      check("wr_in_fetch_pc", pc, 32'h514);
      check("wr_in_fetch_req", {31'd0, fetch_req}, 32'd1);
      fetch("p4tb", 32'h1111_000B, 0);

      // Ack while in DONE must be ignored.
      fetch_ack = 1'b1;
      fetch_data = 32'hDEAD_0001;
      @(negedge clk);
      fetch_ack = 1'b0;
      check("ack_in_done_instr", instr, last_instr);
      check("ack_in_done_iv", {31'd0, instr_valid}, 32'd1);

`ifdef PC_MISALIGN_TRAP_EN
      jal_tgt = 32'h202;
      pc_src = JAL;
      pc_write = 1'b1;
      @(negedge clk);
      pc_write = 1'b0;
      check("mis_pc", pc, exp_pc);
      check("mis_iv", {31'd0, instr_valid}, 32'd1);
      check("mis_req", {31'd0, fetch_req}, 32'd0);
      check("mis_pulse", {31'd0, misalign}, 32'd1);
      @(negedge clk);
      check("mis_fall", {31'd0, misalign}, 32'd0);
      check("mis_pc2", pc, exp_pc);
      mtvec = 32'h400;
      commit("mis_trap", MTVEC, 32'h400);
      fetch("mis_trap", 32'h1111_000C, 0);
`else
      jal_tgt = 32'h202;
      commit("align", JAL, 32'h200);
      fetch("align", 32'h1111_000C, 0);
`endif

      jal_tgt = 32'h200;
      commit("mid", JAL, 32'h200);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_pc", pc, RV);
      check("mid_req", {31'd0, fetch_req}, 32'd0);
      check("mid_instr", instr, NOP_INSTR);
      check("mid_iv", {31'd0, instr_valid}, 32'd0);
      fetch_ack = 1'b1;
      fetch_data = 32'hDEAD_0002;
      @(negedge clk);
      rst_n = 1'b1;
      addr_q.push_back(RV);
      @(negedge clk);
      check("late_ack_instr", instr, NOP_INSTR);
      check("late_ack_iv", {31'd0, instr_valid}, 32'd0);
      fetch_ack = 1'b0;
      await_req("post_rst");
      fetch("post_rst", 32'h0010_0073, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
